// File: rtl/scroll_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : scroll_sequencer_if
// Description : Control and status bundle for the scroll sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface scroll_sequencer_if #(
    parameter int POS_W = 3
) ();
    logic             en;
    logic             tick;
    logic             dir;
    logic [1:0]       mode;
    logic             load;
    logic [POS_W-1:0] load_pos;
    logic [POS_W-1:0] pos;
    logic             cur_dir;
    logic             at_end;
    logic             wrap_pulse;
    logic             done;

    modport master (
        output en, tick, dir, mode, load, load_pos,
        input  pos, cur_dir, at_end, wrap_pulse, done
    );

    modport slave (
        input  en, tick, dir, mode, load, load_pos,
        output pos, cur_dir, at_end, wrap_pulse, done
    );
endinterface
`default_nettype wire

// File: rtl/scroll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scroll_sequencer
// Description : Scroll position sequencer with wrap/bounce/one-shot/hold modes.
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_sequencer #(
    parameter int MAX_POS = 6,
    parameter int POS_W   = 3,
    parameter int DWELL   = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    scroll_sequencer_if.slave  bus
);
    localparam logic [POS_W-1:0] c_MAX_POS      = POS_W'(MAX_POS);
    localparam logic [7:0]       c_DWELL        = 8'(DWELL);
    localparam logic [1:0]       c_MODE_WRAP    = 2'b00;
    localparam logic [1:0]       c_MODE_BOUNCE  = 2'b01;
    localparam logic [1:0]       c_MODE_ONESHOT = 2'b10;
    localparam logic [1:0]       c_MODE_HOLD    = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state,      w_state_next;
    logic [POS_W-1:0] r_pos,        w_pos_next;
    logic             r_cur_dir,    w_dir_next;
    logic [7:0]       r_dwell_cnt,  w_cnt_next;
    logic             r_done,       w_done_next;
    logic             r_wrap_pulse, w_wrap_next;

    logic             w_step;
    logic             w_follow;
    logic             w_step_dir;
    logic             w_outward;
    logic [POS_W-1:0] w_pos_inc;
    logic [POS_W-1:0] w_pos_dec;

    assign w_step     = bus.tick & bus.en & ~bus.load;
    assign w_follow   = (bus.mode == c_MODE_WRAP) || (bus.mode == c_MODE_ONESHOT);
    // Wrap/one-shot steer from the live dir input; bounce keeps its own direction.
    assign w_step_dir = w_follow ? bus.dir : r_cur_dir;
    assign w_outward  = w_step_dir ? (r_pos == c_MAX_POS) : (r_pos == '0);
    assign w_pos_inc  = r_pos + POS_W'(1);
    assign w_pos_dec  = r_pos - POS_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_pos_next   = r_pos;
        w_dir_next   = r_cur_dir;
        w_cnt_next   = r_dwell_cnt;
        w_done_next  = r_done;
        w_wrap_next  = 1'b0;

        if (bus.load) begin
            w_pos_next   = (bus.load_pos > c_MAX_POS) ? c_MAX_POS : bus.load_pos;
            w_dir_next   = bus.dir;
            w_state_next = ST_RUN;
            w_cnt_next   = 8'd0;
            w_done_next  = 1'b0;
        end else if (w_step) begin
            if (w_follow && !(r_state == ST_DONE && bus.mode == c_MODE_ONESHOT))
                w_dir_next = bus.dir;

            case (r_state)
                ST_RUN: begin
                    if (bus.mode != c_MODE_HOLD) begin
                        if (!w_outward) begin
                            w_pos_next = w_step_dir ? w_pos_inc : w_pos_dec;
                        end else begin
                            case (bus.mode)
                                c_MODE_WRAP: begin
                                    w_pos_next  = w_step_dir ? '0 : c_MAX_POS;
                                    w_wrap_next = 1'b1;
                                end
                                c_MODE_BOUNCE: begin
                                    if (c_DWELL == 8'd0) begin
                                        w_dir_next = ~r_cur_dir;
                                        w_pos_next = r_cur_dir ? w_pos_dec : w_pos_inc;
                                    end else begin
                                        w_state_next = ST_DWELL;
                                        w_cnt_next   = 8'd1;
                                    end
                                end
                                default: begin
                                    w_state_next = ST_DONE;
                                    w_done_next  = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_DWELL: begin
                    if (bus.mode == c_MODE_BOUNCE) begin
                        if (r_dwell_cnt == c_DWELL) begin
                            w_dir_next   = ~r_cur_dir;
                            w_pos_next   = r_cur_dir ? w_pos_dec : w_pos_inc;
                            w_cnt_next   = 8'd0;
                            w_state_next = ST_RUN;
                        end else begin
                            w_cnt_next = r_dwell_cnt + 8'd1;
                        end
                    end else begin
                        w_state_next = ST_RUN;
                        w_cnt_next   = 8'd0;
                    end
                end
                ST_DONE: begin
                    if (bus.mode != c_MODE_ONESHOT) begin
                        w_state_next = ST_RUN;
                        w_done_next  = 1'b0;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_pos        <= '0;
            r_cur_dir    <= 1'b1;
            r_dwell_cnt  <= 8'd0;
            r_done       <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pos        <= w_pos_next;
            r_cur_dir    <= w_dir_next;
            r_dwell_cnt  <= w_cnt_next;
            r_done       <= w_done_next;
            r_wrap_pulse <= w_wrap_next;
        end
    end

    assign bus.pos        = r_pos;
    assign bus.cur_dir    = r_cur_dir;
    assign bus.at_end     = (r_pos == '0) || (r_pos == c_MAX_POS);
    assign bus.wrap_pulse = r_wrap_pulse;
    assign bus.done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_scroll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_sequencer
// Description : Self-checking bench: two sequencers (dwell 2 and dwell 0) vs model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_sequencer;
    localparam int MAXP = 6;

    logic       clk;
    logic       reset;
    logic       en, tick, dir, load;
    logic [1:0] mode;
    logic [2:0] load_pos;

    int vectors    = 0;
    int miscompares = 0;

    scroll_sequencer_if #(.POS_W(3)) bus_a ();
    scroll_sequencer_if #(.POS_W(3)) bus_b ();

    assign bus_a.en = en;     assign bus_b.en = en;
    assign bus_a.tick = tick; assign bus_b.tick = tick;
    assign bus_a.dir = dir;   assign bus_b.dir = dir;
    assign bus_a.mode = mode; assign bus_b.mode = mode;
    assign bus_a.load = load; assign bus_b.load = load;
    assign bus_a.load_pos = load_pos;
    assign bus_b.load_pos = load_pos;

    scroll_sequencer #(.MAX_POS(MAXP), .POS_W(3), .DWELL(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    scroll_sequencer #(.MAX_POS(MAXP), .POS_W(3), .DWELL(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase 0 = moving, 1 = lingering at an end, 2 = finished.
    int m_pos[2], m_dir[2], m_phase[2], m_wait[2], m_done[2], m_wp[2];
    bit m_valid = 1'b0;

    task automatic model_step(input int k);
        int dw;
        int going;
        bit at_bound;
        dw = (k == 0) ? 2 : 0;
        m_wp[k] = 0;
        if (reset) begin
            m_pos[k] = 0; m_dir[k] = 1; m_phase[k] = 0;
            m_wait[k] = 0; m_done[k] = 0;
        end else if (load) begin
            m_pos[k] = (int'(load_pos) > MAXP) ? MAXP : int'(load_pos);
            m_dir[k] = int'(dir); m_phase[k] = 0; m_wait[k] = 0; m_done[k] = 0;
        end else if (tick && en) begin
            if ((mode == 2'd0 || mode == 2'd2) && !(m_phase[k] == 2 && mode == 2'd2))
                m_dir[k] = int'(dir);
            if (m_phase[k] == 2) begin
                if (mode != 2'd2) begin m_phase[k] = 0; m_done[k] = 0; end
            end else if (m_phase[k] == 1) begin
                if (mode == 2'd1) begin
                    if (m_wait[k] == dw) begin
                        m_dir[k] = 1 - m_dir[k];
                        m_pos[k] = m_pos[k] + (m_dir[k] == 1 ? 1 : -1);
                        m_phase[k] = 0; m_wait[k] = 0;
                    end else m_wait[k] = m_wait[k] + 1;
                end else begin
                    m_phase[k] = 0; m_wait[k] = 0;
                end
            end else if (mode != 2'd3) begin
                going = m_dir[k];
                at_bound = (going == 1) ? (m_pos[k] == MAXP) : (m_pos[k] == 0);
                if (!at_bound) m_pos[k] = m_pos[k] + (going == 1 ? 1 : -1);
                else if (mode == 2'd0) begin
                    m_pos[k] = (going == 1) ? 0 : MAXP;
                    m_wp[k] = 1;
                end else if (mode == 2'd1) begin
                    if (dw == 0) begin
                        m_dir[k] = 1 - m_dir[k];
                        m_pos[k] = m_pos[k] + (m_dir[k] == 1 ? 1 : -1);
                    end else begin
                        m_phase[k] = 1; m_wait[k] = 1;
                    end
                end else begin
                    m_phase[k] = 2; m_done[k] = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) m_valid = 1'b1;
        if (m_valid) begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("a.pos",        int'(bus_a.pos),        m_pos[0]);
            chk("a.cur_dir",    int'(bus_a.cur_dir),    m_dir[0]);
            chk("a.at_end",     int'(bus_a.at_end),     int'(m_pos[0] == 0 || m_pos[0] == MAXP));
            chk("a.wrap_pulse", int'(bus_a.wrap_pulse), m_wp[0]);
            chk("a.done",       int'(bus_a.done),       m_done[0]);
            chk("b.pos",        int'(bus_b.pos),        m_pos[1]);
            chk("b.cur_dir",    int'(bus_b.cur_dir),    m_dir[1]);
            chk("b.at_end",     int'(bus_b.at_end),     int'(m_pos[1] == 0 || m_pos[1] == MAXP));
            chk("b.wrap_pulse", int'(bus_b.wrap_pulse), m_wp[1]);
            chk("b.done",       int'(bus_b.done),       m_done[1]);
        end
    end

    // Drive one cycle of inputs at the falling edge, return at the next falling edge.
    task automatic cyc(input logic t, input logic ld, input logic [2:0] lp,
                       input logic d, input logic [1:0] m, input logic e, input logic r);
        tick = t; load = ld; load_pos = lp; dir = d; mode = m; en = e; reset = r;
        @(negedge clk);
    endtask

    initial begin
        int exp_seq[6];
        int dir_seq[6];
        logic [1:0] rm;
        logic       rd;
        reset = 1'b1; en = 1'b0; tick = 1'b0; dir = 1'b0;
        load = 1'b0; mode = 2'd0; load_pos = 3'd0;
        @(negedge clk);
        chk("reset.pos",  int'(bus_a.pos), 0);
        chk("reset.dir",  int'(bus_a.cur_dir), 1);
        chk("reset.done", int'(bus_a.done), 0);
        chk("reset.wp",   int'(bus_a.wrap_pulse), 0);

        // Wrap right through the end, then one wrap leftward.
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 0, 0, 1, 2'd0, 1, 0);
            chk("wrap.pos", int'(bus_a.pos), (i == 7) ? 0 : i);
            chk("wrap.wp",  int'(bus_a.wrap_pulse), (i == 7) ? 1 : 0);
        end
        cyc(1, 0, 0, 0, 2'd0, 1, 0);
        chk("wrapl.pos", int'(bus_a.pos), 6);
        chk("wrapl.wp",  int'(bus_a.wrap_pulse), 1);
        cyc(0, 0, 0, 0, 2'd0, 1, 0);
        chk("wrap.wp_clear", int'(bus_a.wrap_pulse), 0);

        // Bounce with a two-tick dwell.
        cyc(0, 1, 3'd4, 1, 2'd1, 1, 0);
        chk("bounce.load", int'(bus_a.pos), 4);
        exp_seq = '{5, 6, 6, 6, 5, 4};
        dir_seq = '{1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0, 0, 2'd1, 1, 0);
            chk("bounce.pos", int'(bus_a.pos), exp_seq[i]);
            chk("bounce.dir", int'(bus_a.cur_dir), dir_seq[i]);
            chk("bounce.at_end", int'(bus_a.at_end), (exp_seq[i] == 6) ? 1 : 0);
        end

        // Bounce without dwell, dir input toggling.
        cyc(0, 1, 3'd5, 1, 2'd1, 1, 0);
        exp_seq = '{6, 5, 4, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, logic'(i % 2), 2'd1, 1, 0);
            chk("bounce0.pos", int'(bus_b.pos), exp_seq[i]);
        end

        // One-shot leftward from 2.
        cyc(0, 1, 3'd2, 0, 2'd2, 1, 0);
        exp_seq = '{1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 2'd2, 1, 0);
            chk("oneshot.pos",  int'(bus_a.pos), exp_seq[i]);
            chk("oneshot.done", int'(bus_a.done), (i >= 2) ? 1 : 0);
        end
        cyc(0, 1, 3'd3, 0, 2'd2, 1, 0);
        chk("oneshot.load_clears", int'(bus_a.done), 0);
        chk("oneshot.load_pos",    int'(bus_a.pos), 3);

        // Load clamp beats a same-cycle tick; en=0 freezes.
        cyc(1, 1, 3'd7, 1, 2'd0, 1, 0);
        chk("clamp.pos", int'(bus_a.pos), 6);
        chk("clamp.wp",  int'(bus_a.wrap_pulse), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 1, 2'd0, 0, 0);
            chk("en0.pos", int'(bus_a.pos), 6);
        end

        // Reset while lingering.
        cyc(0, 1, 3'd6, 1, 2'd1, 1, 0);
        cyc(1, 0, 0, 1, 2'd1, 1, 0);
        chk("dwell.enter", int'(bus_a.pos), 6);
        cyc(1, 1, 3'd3, 0, 2'd1, 1, 1);
        chk("rst_dwell.pos", int'(bus_a.pos), 0);
        chk("rst_dwell.dir", int'(bus_a.cur_dir), 1);
        cyc(1, 0, 0, 0, 2'd1, 1, 0);
        chk("rst_dwell.step", int'(bus_a.pos), 1);

        // Randomized traffic; mode and dir change only occasionally.
        rm = 2'd1; rd = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  rd = ~rd;
            cyc(logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 11) == 0),
                3'($urandom_range(0, 7)),
                rd, rm,
                logic'($urandom_range(0, 4) != 0),
                logic'($urandom_range(0, 249) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
